// File: rtl/sync_fifo_flagged.sv
// Single-clock FIFO with programmable almost-full/almost-empty levels,
// fill-level output, sticky error flags and FWFT or registered read mode.
module sync_fifo_flagged #(
  parameter int WIDTH     = 8,
  parameter int DEPTH_LEN = 4,
  parameter int AF_LEVEL  = 12,
  parameter int AE_LEVEL  = 2,
  parameter int FWFT      = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [WIDTH-1:0]     i_data,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic                 i_clr_err,
  output logic [WIDTH-1:0]     o_data,
  output logic                 o_valid,
  output logic                 o_full,
  output logic                 o_empty,
  output logic                 o_almost_full,
  output logic                 o_almost_empty,
  output logic [DEPTH_LEN:0]   o_fill,
  output logic                 o_overflow,
  output logic                 o_underflow
);

  localparam int DEPTH = 1 << DEPTH_LEN;
  localparam logic [DEPTH_LEN:0] DEPTH_W = (DEPTH_LEN+1)'(DEPTH);
  localparam logic [DEPTH_LEN:0] AF_W    = (DEPTH_LEN+1)'(AF_LEVEL);
  localparam logic [DEPTH_LEN:0] AE_W    = (DEPTH_LEN+1)'(AE_LEVEL);

  // Thresholds outside the representable fill range make the flags useless.
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("sync_fifo_flagged: AF_LEVEL out of range 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_flagged: AE_LEVEL out of range 0..DEPTH-1");
  end
  if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
    $error("sync_fifo_flagged: FWFT must be 0 or 1");
  end

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [DEPTH_LEN:0]   r_wr_ptr;
  logic [DEPTH_LEN:0]   r_rd_ptr;
  logic                 r_overflow;
  logic                 r_underflow;

  logic [DEPTH_LEN:0]   w_fill;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_wr_req;
  logic                 w_rd_req;
  logic [DEPTH_LEN-1:0] w_wr_addr;
  logic [DEPTH_LEN-1:0] w_rd_addr;

  // Occupancy and flags come straight from the registered pointers.
  always_comb begin
    w_fill    = r_wr_ptr - r_rd_ptr;
    w_full    = (w_fill == DEPTH_W);
    w_empty   = (w_fill == '0);
    w_wr_req  = wr_en & ~w_full;
    w_rd_req  = rd_en & ~w_empty;
    w_wr_addr = r_wr_ptr[DEPTH_LEN-1:0];
    w_rd_addr = r_rd_ptr[DEPTH_LEN-1:0];
  end

  assign o_fill         = w_fill;
  assign o_full         = w_full;
  assign o_empty        = w_empty;
  assign o_almost_full  = (w_fill >= AF_W);
  assign o_almost_empty = (w_fill <= AE_W);
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

  // Pointer advance on accepted requests; reset discards all contents.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_req) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_req) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage array; not reset, stale words are unreachable after reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_wr_req) r_mem[w_wr_addr] <= i_data;
  end

  // Sticky error flags; a new error on the clearing edge wins.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && w_full)   r_overflow <= 1'b1;
      else if (i_clr_err)    r_overflow <= 1'b0;
      if (rd_en && w_empty)  r_underflow <= 1'b1;
      else if (i_clr_err)    r_underflow <= 1'b0;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head of queue is always presented; rd_en only pops it.
    assign o_data  = r_mem[w_rd_addr];
    assign o_valid = ~w_empty;
  end else begin : g_regrd
    logic [WIDTH-1:0] r_rdata;
    logic             r_rvalid;

    // Registered read: data lands one cycle after an accepted rd_en.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_rdata  <= '0;
        r_rvalid <= 1'b0;
      end else if (w_rd_req) begin
        r_rdata  <= r_mem[w_rd_addr];
        r_rvalid <= 1'b1;
      end else begin
        r_rvalid <= 1'b0;
      end
    end

    assign o_data  = r_rdata;
    assign o_valid = r_rvalid;
  end

endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Bench for sync_fifo_flagged: FWFT and registered-read instances share
// stimulus and are checked against a queue-based reference model.
module tb_sync_fifo_flagged;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [7:0] i_data = '0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       i_clr_err = 1'b0;

  logic [7:0] f_data, r_data;
  logic       f_valid, r_valid;
  logic       f_full, r_full, f_empty, r_empty;
  logic       f_af, r_af, f_ae, r_ae;
  logic [4:0] f_fill, r_fill;
  logic       f_ovf, r_ovf, f_udf, r_udf;

  always #5 clk = ~clk;

  sync_fifo_flagged #(.FWFT(1)) u_fwft (
    .i_clk(clk), .i_rst(i_rst), .i_data(i_data),
    .wr_en(wr_en), .rd_en(rd_en), .i_clr_err(i_clr_err),
    .o_data(f_data), .o_valid(f_valid), .o_full(f_full),
    .o_empty(f_empty), .o_almost_full(f_af),
    .o_almost_empty(f_ae), .o_fill(f_fill),
    .o_overflow(f_ovf), .o_underflow(f_udf));

  sync_fifo_flagged #(.FWFT(0)) u_reg (
    .i_clk(clk), .i_rst(i_rst), .i_data(i_data),
    .wr_en(wr_en), .rd_en(rd_en), .i_clr_err(i_clr_err),
    .o_data(r_data), .o_valid(r_valid), .o_full(r_full),
    .o_empty(r_empty), .o_almost_full(r_af),
    .o_almost_empty(r_ae), .o_fill(r_fill),
    .o_overflow(r_ovf), .o_underflow(r_udf));

  localparam int DEPTH = 16;
  localparam int AF = 12;
  localparam int AE = 2;

  logic [7:0] q[$];
  bit         m_ovf, m_udf, m_rv;
  logic [7:0] m_rd;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("fill_f", 32'(f_fill), n);
    chk("fill_r", 32'(r_fill), n);
    chk("empty_f", 32'(f_empty), 32'(n == 0));
    chk("empty_r", 32'(r_empty), 32'(n == 0));
    chk("full_f", 32'(f_full), 32'(n == DEPTH));
    chk("full_r", 32'(r_full), 32'(n == DEPTH));
    chk("af_f", 32'(f_af), 32'(n >= AF));
    chk("af_r", 32'(r_af), 32'(n >= AF));
    chk("ae_f", 32'(f_ae), 32'(n <= AE));
    chk("ae_r", 32'(r_ae), 32'(n <= AE));
    chk("ovf_f", 32'(f_ovf), 32'(m_ovf));
    chk("ovf_r", 32'(r_ovf), 32'(m_ovf));
    chk("udf_f", 32'(f_udf), 32'(m_udf));
    chk("udf_r", 32'(r_udf), 32'(m_udf));
    chk("valid_f", 32'(f_valid), 32'(n != 0));
    if (n != 0) chk("data_f", 32'(f_data), 32'(q[0]));
    chk("valid_r", 32'(r_valid), 32'(m_rv));
    chk("data_r", 32'(r_data), 32'(m_rd));
  endtask

  // One clock of stimulus; the model is advanced from the pre-edge state.
  task automatic step(input bit rst, input bit wr, input bit rd,
                      input bit clr, input logic [7:0] d);
    bit         full, empty;
    logic [7:0] pop;
    pop = '0;
    i_rst = rst; wr_en = wr; rd_en = rd; i_clr_err = clr; i_data = d;
    full  = (q.size() == DEPTH);
    empty = (q.size() == 0);
    if (rst) begin
      q.delete();
      m_ovf = 0; m_udf = 0; m_rv = 0; m_rd = '0;
    end else begin
      if (rd && !empty) pop = q.pop_front();
      if (wr && !full) q.push_back(d);
      m_ovf = (wr && full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
      m_udf = (rd && empty) ? 1'b1 : (clr ? 1'b0 : m_udf);
      m_rv = rd && !empty;
      if (m_rv) m_rd = pop;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    // reset state
    step(1, 0, 0, 0, 8'h00);
    step(1, 0, 0, 0, 8'h00);

    // fill 0x00..0x0F, flags tracked each cycle
    for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 8'(i));
    // write while full: rejected, overflow sticky
    step(0, 1, 0, 0, 8'hAA);
    step(0, 0, 0, 0, 8'h00);
    // drain in order
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 8'h00);
    // read while empty, then clear
    step(0, 0, 1, 0, 8'h00);
    step(0, 0, 0, 1, 8'h00);
    // empty with wr+rd: write taken, underflow set
    step(0, 1, 1, 0, 8'h33);
    step(0, 0, 1, 1, 8'h00);
    // clear and new error on same edge: set wins
    step(0, 0, 1, 1, 8'h00);
    step(0, 0, 0, 1, 8'h00);

    // registered read latency
    step(1, 0, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h05);
    step(0, 1, 0, 0, 8'h06);
    step(0, 0, 1, 0, 8'h00);
    step(0, 0, 1, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);

    // wrap-around streaming at constant fill 4
    step(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 8'(8'h80 + i));
    for (int i = 0; i < 40; i++) step(0, 1, 1, 0, 8'($urandom));

    // full with wr+rd: read taken, write rejected
    for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 8'($urandom));
    step(0, 1, 1, 0, 8'hEE);
    step(0, 0, 0, 1, 8'h00);

    // reset mid-operation at fill 9
    step(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 9; i++) step(0, 1, 0, 0, 8'(8'h40 + i));
    step(1, 1, 1, 0, 8'hFF);
    step(0, 1, 0, 0, 8'h77);
    step(0, 0, 1, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);

    // random traffic in write-heavy, balanced and read-heavy phases
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 150; i++) begin
        bit w, r, c, rs;
        w  = ($urandom_range(0, 3) < 3 - ph);
        r  = ($urandom_range(0, 3) < 1 + ph);
        c  = ($urandom_range(0, 15) == 0);
        rs = ($urandom_range(0, 99) == 0);
        step(rs, w, r, c, 8'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
